// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states,
// iteration count and a conditional-negate helper.
package hilo_mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Restoring-divide datapath for hilo_mdu: one quotient bit per step on unsigned
// magnitudes; the owning FSM decides when to load and step.
module hilo_mdu_div_iter
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o
);

  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]      shifted;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[31]};
    if (load_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      // The partial remainder stays below the divisor, so the difference fits in 32 bits.
      if (shifted >= {1'b0, dvsr_q}) begin
        rem_d = shifted[31:0] - dvsr_q;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning HI/LO, with same-cycle bypass of the completing result.
// Define HILO_MDU_FAST_MUL_EN to replace the 32-cycle shift-add multiply with a single-cycle one.
module hilo_mdu
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        done,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             is_div_q, is_div_d;
  logic             skip_q, skip_d;

  logic        is_mul_op, is_div_op, is_signed, sign_a, sign_b;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_res;
  logic [31:0] fin_hi, fin_lo;
  logic        div_load, div_step, div_last;
  logic [31:0] div_quo, div_rem;

  assign is_mul_op = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  assign is_div_op = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  assign is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  assign sign_a    = is_signed & src_a[31];
  assign sign_b    = is_signed & src_b[31];
  assign a_mag     = cond_neg32(src_a, sign_a);
  assign b_mag     = cond_neg32(src_b, sign_b);

  // Shift-add: product register holds {partial sum, unconsumed multiplier bits}.
  assign mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

`ifdef HILO_MDU_FAST_MUL_EN
  logic [32:0] a_ext, b_ext;
  logic [65:0] fast_prod;
  assign a_ext     = {sign_a, src_a};
  assign b_ext     = {sign_b, src_b};
  assign fast_prod = $signed({{33{a_ext[32]}}, a_ext}) * $signed({{33{b_ext[32]}}, b_ext});
`endif

  hilo_mdu_div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  // A divide by zero completes without touching HI/LO, so the "result" is the old contents.
  assign mul_res = cond_neg64(prod_q, neg_q);
  assign fin_hi  = skip_q ? hi_q : (is_div_q ? cond_neg32(div_rem, rem_neg_q) : mul_res[63:32]);
  assign fin_lo  = skip_q ? lo_q : (is_div_q ? cond_neg32(div_quo, neg_q)     : mul_res[31:0]);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    skip_d    = skip_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    stallreq  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stallreq = start & (is_mul_op | is_div_op);
        if (start && !flush) begin
          if (is_mul_op) begin
            is_div_d = 1'b0;
            skip_d   = 1'b0;
`ifdef HILO_MDU_FAST_MUL_EN
            prod_d   = fast_prod[63:0];
            neg_d    = 1'b0;
            state_d  = ST_FIN;
`else
            mcand_d  = a_mag;
            prod_d   = {32'd0, b_mag};
            cnt_d    = '0;
            neg_d    = sign_a ^ sign_b;
            state_d  = ST_MUL;
`endif
          end else if (is_div_op) begin
            is_div_d  = 1'b1;
            neg_d     = sign_a ^ sign_b;
            rem_neg_d = sign_a;
            if (src_b != 32'd0) begin
              div_load = 1'b1;
              skip_d   = 1'b0;
              state_d  = ST_DIV;
            end else begin
              skip_d  = 1'b1;
              state_d = ST_FIN;
            end
          end else if (op == MDU_OP_MTHI) begin
            hi_d = src_a;
          end else if (op == MDU_OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_MUL: begin
        stallreq = 1'b1;
        prod_d   = {mul_sum, prod_q[31:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (flush)                            state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(ITER - 1))   state_d = ST_FIN;
      end
      ST_DIV: begin
        stallreq = 1'b1;
        div_step = 1'b1;
        if (flush)         state_d = ST_IDLE;
        else if (div_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        // The op has already left EX, so a flush here must not cancel the write.
        done    = 1'b1;
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
      skip_q    <= skip_d;
    end
  end

  assign hi_rdata = done ? fin_hi : hi_q;
  assign lo_rdata = done ? fin_lo : lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu: mul/div results, stall length, divide by zero,
// flush in flight and in FIN, MT writes, and reset mid-divide.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stallreq, done;
  logic [31:0] hi_rdata, lo_rdata;

  int vectors = 0;
  int miscompares = 0;

  int          stalls, dones, done_at, n;
  logic [31:0] dh, dl;

  hilo_mdu dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .done     (done),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and watch a bounded window, recording stall cycles and the done pulse.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int st, output int dn, output int at,
                        output logic [31:0] h, output logic [31:0] l);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    st = 0; dn = 0; at = -1; h = '0; l = '0;
    for (int i = 0; i < 45; i++) begin
      if (stallreq) st++;
      if (done) begin
        dn++; at = i; h = hi_rdata; l = lo_rdata;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; src_a = a;
    cyc();
    start = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    check("rst_stallreq", {31'd0, stallreq}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_hi",       hi_rdata,          32'd0);
    check("rst_lo",       lo_rdata,          32'd0);
    rst = 1'b0;
    cyc();

    // MTHI / MTLO: no stall, visible next cycle
    start = 1'b1; op = 3'd4; src_a = 32'h1234;
    #1;
    check("mthi_no_stall", {31'd0, stallreq}, 32'd0);
    cyc(); start = 1'b0; #1;
    check("mthi_hi", hi_rdata, 32'h1234);
    mt(3'd5, 32'h5678);
    check("mtlo_lo",   lo_rdata,         32'h5678);
    check("mtlo_done", {31'd0, done},    32'd0);

    // MULT -2 * 3
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, stalls, dones, done_at, dh, dl);
    check("mult_stalls",  stalls,  32'd33);
    check("mult_dones",   dones,   32'd1);
    check("mult_done_at", done_at, 32'd33);
    check("mult_hi_byp",  dh,      32'hFFFF_FFFF);
    check("mult_lo_byp",  dl,      32'hFFFF_FFFA);
    check("mult_hi_reg",  hi_rdata, 32'hFFFF_FFFF);
    check("mult_lo_reg",  lo_rdata, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    run_op(3'd3, 32'd100, 32'd7, stalls, dones, done_at, dh, dl);
    check("divu_stalls", stalls, 32'd33);
    check("divu_dones",  dones,  32'd1);
    check("divu_lo",     dl,     32'd14);
    check("divu_hi",     dh,     32'd2);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, stalls, dones, done_at, dh, dl);
    check("div_neg_lo", dl, 32'hFFFF_FFFD);
    check("div_neg_hi", dh, 32'hFFFF_FFFF);

    // DIV 5 / 0 keeps preloaded HI/LO
    mt(3'd4, 32'h1234);
    mt(3'd5, 32'h5678);
    run_op(3'd2, 32'd5, 32'd0, stalls, dones, done_at, dh, dl);
    check("div0_stalls", stalls,   32'd1);
    check("div0_dones",  dones,    32'd1);
    check("div0_hi_byp", dh,       32'h1234);
    check("div0_lo_byp", dl,       32'h5678);
    check("div0_hi_reg", hi_rdata, 32'h1234);
    check("div0_lo_reg", lo_rdata, 32'h5678);

    // MULTU max * max
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, dones, done_at, dh, dl);
    check("multu_hi", dh, 32'hFFFF_FFFE);
    check("multu_lo", dl, 32'h0000_0001);

    // DIV most-negative / -1
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, stalls, dones, done_at, dh, dl);
    check("div_ovf_lo", dl, 32'h8000_0000);
    check("div_ovf_hi", dh, 32'h0000_0000);

    // MULT 6 * 7
    run_op(3'd0, 32'd6, 32'd7, stalls, dones, done_at, dh, dl);
`ifdef HILO_MDU_FAST_MUL_EN
    check("mul67_stalls",  stalls,  32'd1);
    check("mul67_done_at", done_at, 32'd1);
`else
    check("mul67_stalls",  stalls,  32'd33);
    check("mul67_done_at", done_at, 32'd33);
`endif
    check("mul67_hi", dh, 32'd0);
    check("mul67_lo", dl, 32'd42);

    // Flush at iteration 10 of DIVU
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("flush_pre_stall", {31'd0, stallreq}, 32'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    check("flush_stallreq", {31'd0, stallreq}, 32'd0);
    check("flush_hi",       hi_rdata,          32'd0);
    check("flush_lo",       lo_rdata,          32'd42);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      cyc();
    end
    check("flush_no_done", dones, 32'd0);
    mt(3'd5, 32'hA5);
    check("flush_mtlo", lo_rdata, 32'hA5);

    // Flush + start in IDLE: nothing happens
    flush = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'hDEAD;
    cyc();
    op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    cyc();
    flush = 1'b0; start = 1'b0;
    #1;
    check("fs_idle_hi",    hi_rdata,          32'd0);
    check("fs_idle_stall", {31'd0, stallreq}, 32'd0);
    cyc();
    check("fs_idle_done",  {31'd0, done},     32'd0);
    check("fs_idle_stall2", {31'd0, stallreq}, 32'd0);

    // Flush in FIN still commits (DIVU 9 / 4)
    start = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd4;
    cyc();
    start = 1'b0;
    #1;
    n = 0;
    while (!done && n < 50) begin
      cyc();
      n++;
    end
    check("finflush_reached", {31'd0, done}, 32'd1);
    flush = 1'b1;
    #1;
    check("finflush_byp_lo", lo_rdata, 32'd2);
    cyc();
    flush = 1'b0;
    #1;
    check("finflush_lo",   lo_rdata,      32'd2);
    check("finflush_hi",   hi_rdata,      32'd1);
    check("finflush_done", {31'd0, done}, 32'd0);

    // Reset mid-DIV
    start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b1;
    cyc();
    check("rstmid_stallreq", {31'd0, stallreq}, 32'd0);
    check("rstmid_done",     {31'd0, done},     32'd0);
    check("rstmid_hi",       hi_rdata,          32'd0);
    check("rstmid_lo",       lo_rdata,          32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || stallreq) dones++;
      cyc();
    end
    check("rstmid_quiet", dones, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
